// File: rtl/sha256_pkg.sv
// Shared state encoding, padding constants and word helpers for the SHA-256 padder.
package sha256_pkg;

  localparam int          BLOCK_WORDS = 16;
  localparam logic [31:0] PAD_WORD    = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MSG   = 3'd1,
    ST_PAD   = 3'd2,
    ST_ZERO  = 3'd3,
    ST_LENHI = 3'd4,
    ST_LENLO = 3'd5
  } state_e;

  // Zero words needed so that L + 3 + Z is a multiple of 16; only L mod 16 matters.
  function automatic logic [3:0] zero_words(input logic [3:0] len_lo);
    return 4'd0 - (len_lo + 4'd3);
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sha256_skid.sv
// Two-entry output buffer absorbing downstream backpressure; entry 0 drives the outputs.
module sha256_skid #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d, cnt_pop_s;

  // Shift on pop, then write the new entry into the first free slot.
  always_comb begin
    cnt_pop_s = cnt_q - {1'b0, pop_i};
    e1_d      = e1_q;
    if (pop_i) begin
      e0_d = e1_q;
    end else begin
      e0_d = e0_q;
    end
    if (push_i) begin
      if (cnt_pop_s == 2'd0) begin
        e0_d = push_data_i;
      end else begin
        e1_d = push_data_i;
      end
    end else begin
      e1_d = e1_d;
    end
    cnt_d = cnt_pop_s + {1'b0, push_i};
  end

  // Buffer storage with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      e0_q  <= {W{1'b0}};
      e1_q  <= {W{1'b0}};
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = e0_q;
  assign count_o     = cnt_q;

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: streams message words, 0x80000000, zero fill and 64-bit bit length.
// Define SHA256_PAD_BSWAP_EN to byte-reverse message words (padding/length words untouched).
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [LEN_W-1:0]  msg_words,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_read_data,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [31:0]       w_data,
  output logic              w_blk_last,
  output logic              w_msg_last,
  output logic              busy,
  output logic              done
);

  state_e              state_q, state_d, next_s, eff_state_s;
  logic [LEN_W-1:0]    len_q, len_d, cnt_q, cnt_d, eff_len_s, eff_cnt_s;
  logic [3:0]          zero_q, zero_d, eff_zero_s, blk_q, blk_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, eff_addr_s;
  logic                lensent_q, lensent_d, done_q, done_d;
  logic                infl_q, infl_msg_q, infl_last_q;
  logic [31:0]         infl_const_q, msg_word_s;
  logic                pop_s, final_s, accept_s, credit_s;
  logic                issue_s, issue_msg_s, issue_last_s;
  logic [31:0]         issue_const_s;
  logic [2:0]          occ_s;
  logic [1:0]          skid_cnt_s;
  logic                skid_valid_s;
  logic [32:0]         skid_data_s;

  // Issue side: a word may be issued only if it is guaranteed a buffer slot when its data lands.
  always_comb begin
    pop_s    = w_valid && w_ready;
    final_s  = pop_s && w_msg_last;
    accept_s = reset_n && (state_q == ST_IDLE) && start && !done_q;
    occ_s    = {1'b0, skid_cnt_s} + {2'b00, infl_q} - {2'b00, pop_s};
    credit_s = reset_n && (occ_s <= 3'd1);
    if (state_q == ST_IDLE) begin
      eff_state_s = accept_s ? ((msg_words != {LEN_W{1'b0}}) ? ST_MSG : ST_PAD) : ST_IDLE;
      eff_len_s   = msg_words;
      eff_cnt_s   = {LEN_W{1'b0}};
      eff_zero_s  = zero_words(msg_words[3:0]);
      eff_addr_s  = message_addr;
    end else begin
      eff_state_s = state_q;
      eff_len_s   = len_q;
      eff_cnt_s   = cnt_q;
      eff_zero_s  = zero_q;
      eff_addr_s  = addr_q + ADDR_W'(1);
    end
    next_s        = eff_state_s;
    len_d         = eff_len_s;
    cnt_d         = eff_cnt_s;
    zero_d        = eff_zero_s;
    addr_d        = addr_q;
    lensent_d     = final_s ? 1'b0 : lensent_q;
    done_d        = final_s;
    issue_s       = 1'b0;
    issue_msg_s   = 1'b0;
    issue_last_s  = 1'b0;
    issue_const_s = 32'h0000_0000;
    if (credit_s) begin
      case (eff_state_s)
        ST_MSG: begin
          issue_s     = 1'b1;
          issue_msg_s = 1'b1;
          addr_d      = eff_addr_s;
          cnt_d       = eff_cnt_s + LEN_W'(1);
          next_s      = (eff_cnt_s == eff_len_s - LEN_W'(1)) ? ST_PAD : ST_MSG;
        end
        ST_PAD: begin
          issue_s       = 1'b1;
          issue_const_s = PAD_WORD;
          next_s        = (eff_zero_s == 4'd0) ? ST_LENHI : ST_ZERO;
        end
        ST_ZERO: begin
          issue_s = 1'b1;
          zero_d  = eff_zero_s - 4'd1;
          next_s  = (eff_zero_s == 4'd1) ? ST_LENHI : ST_ZERO;
        end
        ST_LENHI: begin
          issue_s = 1'b1;
          next_s  = ST_LENLO;
        end
        ST_LENLO: begin
          // The state is held until this word leaves the buffer, so it is issued once.
          if (!lensent_q) begin
            issue_s       = 1'b1;
            issue_last_s  = 1'b1;
            issue_const_s = {{(32-LEN_W-5){1'b0}}, eff_len_s, 5'b0_0000};
            lensent_d     = 1'b1;
          end else begin
            issue_s = 1'b0;
          end
        end
        default: issue_s = 1'b0;
      endcase
    end else begin
      issue_s = 1'b0;
    end
    if (final_s) begin
      state_d = ST_IDLE;
    end else begin
      state_d = next_s;
    end
    blk_d = pop_s ? (blk_q + 4'd1) : blk_q;
  end

`ifdef SHA256_PAD_BSWAP_EN
  assign msg_word_s = bswap32(mem_read_data);
`else
  assign msg_word_s = mem_read_data;
`endif

  // Control state plus the one-deep read pipeline that meets the memory's data latency.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      len_q        <= {LEN_W{1'b0}};
      cnt_q        <= {LEN_W{1'b0}};
      zero_q       <= 4'd0;
      addr_q       <= {ADDR_W{1'b0}};
      lensent_q    <= 1'b0;
      done_q       <= 1'b0;
      blk_q        <= 4'd0;
      infl_q       <= 1'b0;
      infl_msg_q   <= 1'b0;
      infl_last_q  <= 1'b0;
      infl_const_q <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      zero_q       <= zero_d;
      addr_q       <= addr_d;
      lensent_q    <= lensent_d;
      done_q       <= done_d;
      blk_q        <= blk_d;
      infl_q       <= issue_s;
      infl_msg_q   <= issue_msg_s;
      infl_last_q  <= issue_last_s;
      infl_const_q <= issue_const_s;
    end
  end

  sha256_skid #(.W(33)) u_skid (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (infl_q),
    .push_data_i ({infl_last_q, infl_msg_q ? msg_word_s : infl_const_q}),
    .pop_i       (pop_s),
    .out_valid_o (skid_valid_s),
    .out_data_o  (skid_data_s),
    .count_o     (skid_cnt_s)
  );

  // The address bus parks on the last address read, so it never leaves the message range.
  assign mem_addr   = issue_msg_s ? eff_addr_s : addr_q;
  assign w_valid    = skid_valid_s;
  assign w_data     = skid_data_s[31:0];
  assign w_msg_last = skid_valid_s && skid_data_s[32];
  assign w_blk_last = skid_valid_s && (blk_q == 4'(BLOCK_WORDS - 1));
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: randomized backpressure against a queue-based padding model.
module tb_sha256_padder;

  logic        clk = 1'b0;
  logic        reset_n, start, w_ready;
  logic [15:0] message_addr, mem_addr;
  logic [7:0]  msg_words;
  logic [31:0] mem_read_data, w_data;
  logic        w_valid, w_blk_last, w_msg_last, busy, done;

  logic [31:0] mem [0:65535];
  int          errors = 0;
  int          checks = 0;

  logic [31:0] obs_data[$];
  logic        obs_blk[$];
  logic        obs_msg[$];
  logic [31:0] exp_data[$];
  int          obs_done, obs_first, obs_last, obs_stable_err, obs_addr_err, obs_busy_err, obs_after_err;
  bit          obs_timeout;

  sha256_padder #(.ADDR_W(16), .LEN_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .message_addr(message_addr),
    .msg_words(msg_words), .mem_addr(mem_addr), .mem_read_data(mem_read_data),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_blk_last(w_blk_last),
    .w_msg_last(w_msg_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data for an address appears the cycle after it is presented.
  always @(posedge clk) mem_read_data <= mem[mem_addr];

  task automatic build_expected(input logic [15:0] a, input logic [7:0] l);
    logic [15:0] ad;
    logic [31:0] w;
    exp_data.delete();
    for (int i = 0; i < int'(l); i++) begin
      ad = a + 16'(i);
      w  = mem[ad];
`ifdef SHA256_PAD_BSWAP_EN
      w  = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
      exp_data.push_back(w);
    end
    exp_data.push_back(32'h8000_0000);
    while ((exp_data.size() + 2) % 16 != 0) exp_data.push_back(32'h0);
    exp_data.push_back(32'h0);
    exp_data.push_back(32'(l) * 32'd32);
  endtask

  task automatic run_stream(input logic [15:0] a, input logic [7:0] l, input int pct);
    int          cyc;
    bit          prev_stall, finished;
    logic [31:0] prev_data;
    logic        prev_blk, prev_msg;
    logic [15:0] off;
    obs_data.delete(); obs_blk.delete(); obs_msg.delete();
    obs_done = 0; obs_first = -1; obs_last = -1; obs_stable_err = 0;
    obs_addr_err = 0; obs_busy_err = 0; obs_after_err = 0; obs_timeout = 0;
    @(negedge clk);
    start = 1'b1; message_addr = a; msg_words = l; w_ready = 1'b0;
    @(negedge clk);
    cyc = 1; finished = 0; prev_stall = 0;
    prev_data = 32'h0; prev_blk = 1'b0; prev_msg = 1'b0;
    while (!finished && cyc < 3000) begin
      w_ready      = ($urandom_range(99) < pct);
      start        = (cyc == 5);
      message_addr = 16'($urandom);
      msg_words    = 8'($urandom);
      #1;
      if (l != 8'd0) begin
        off = mem_addr - a;
        if (off >= {8'h00, l}) obs_addr_err++;
      end
      if (prev_stall && !(w_valid && w_data === prev_data && w_blk_last === prev_blk && w_msg_last === prev_msg))
        obs_stable_err++;
      if (w_valid && obs_first < 0) obs_first = cyc;
      if (done) begin
        obs_done++;
        if (busy !== 1'b0) obs_busy_err++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        if (busy !== 1'b0 || done !== 1'b0 || w_valid !== 1'b0) obs_after_err++;
        finished = 1;
      end else begin
        if (busy !== 1'b1) obs_busy_err++;
        if (w_valid && w_ready) begin
          obs_data.push_back(w_data); obs_blk.push_back(w_blk_last); obs_msg.push_back(w_msg_last);
          obs_last = cyc;
        end
        prev_stall = w_valid && !w_ready;
        prev_data = w_data; prev_blk = w_blk_last; prev_msg = w_msg_last;
        @(negedge clk);
        cyc++;
      end
    end
    if (!finished) obs_timeout = 1;
    start = 1'b0;
  endtask

  task automatic test_padding_stream(input string name, input logic [15:0] a, input logic [7:0] l, input int pct);
    build_expected(a, l);
    run_stream(a, l, pct);
    checks++;
    if (obs_timeout) begin errors++; $display("FAIL %s timeout: done not seen within cycle budget", name); end
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      errors++; $display("FAIL %s count: got %0d words want %0d", name, obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_blk[i] !== (i % 16 == 15) || obs_msg[i] !== (i == exp_data.size() - 1)) begin
        errors++;
        $display("FAIL %s word %0d: got data=%h blk=%0b last=%0b want data=%h blk=%0b last=%0b", name, i,
                 obs_data[i], obs_blk[i], obs_msg[i], exp_data[i], (i % 16 == 15), (i == exp_data.size() - 1));
      end
    end
    checks++;
    if (obs_done != 1) begin errors++; $display("FAIL %s done pulses: got %0d want 1", name, obs_done); end
    checks++;
    if (obs_stable_err != 0) begin errors++; $display("FAIL %s stall stability: got %0d changes want 0", name, obs_stable_err); end
    checks++;
    if (obs_addr_err != 0) begin errors++; $display("FAIL %s address range: got %0d bad cycles want 0", name, obs_addr_err); end
    checks++;
    if (obs_busy_err != 0 || obs_after_err != 0) begin
      errors++; $display("FAIL %s busy/done/restart: got busy_err=%0d after_err=%0d want 0", name, obs_busy_err, obs_after_err);
    end
    checks++;
    if (obs_first < 1 || obs_first > 2) begin errors++; $display("FAIL %s first valid: got cycle %0d want 1..2", name, obs_first); end
    if (pct == 100) begin
      checks++;
      if (obs_last - obs_first != exp_data.size() - 1) begin
        errors++; $display("FAIL %s throughput: got span %0d want %0d", name, obs_last - obs_first, exp_data.size() - 1);
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; w_ready = 1'b0; message_addr = 16'h0; msg_words = 8'h0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (w_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || w_data !== 32'h0 || mem_addr !== 16'h0 ||
        w_blk_last !== 1'b0 || w_msg_last !== 1'b0) begin
      errors++;
      $display("FAIL reset state: got valid=%0b busy=%0b done=%0b data=%h addr=%h blk=%0b last=%0b want all zero",
               w_valid, busy, done, w_data, mem_addr, w_blk_last, w_msg_last);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_l20;
    for (int i = 0; i < 20; i++) mem[16'h0100 + 16'(i)] = 32'(i + 1);
    test_padding_stream("L20", 16'h0100, 8'd20, 100);
    checks++;
    if (obs_data.size() != 32 || obs_data[0] !== 32'd1 || obs_data[19] !== 32'd20 || obs_data[20] !== 32'h8000_0000 ||
        obs_data[29] !== 32'h0 || obs_data[31] !== 32'd640 || obs_blk[15] !== 1'b1 || obs_blk[31] !== 1'b1) begin
      errors++;
      $display("FAIL L20 fixed words: got n=%0d w0=%h w20=%h w31=%h want 32,1,80000000,640", obs_data.size(),
               obs_data[0], obs_data[20], obs_data[31]);
    end
  endtask

  task automatic test_l0;
    test_padding_stream("L0", 16'h0000, 8'd0, 100);
    checks++;
    if (obs_data.size() != 16 || obs_data[0] !== 32'h8000_0000 || obs_data[15] !== 32'h0 || obs_msg[15] !== 1'b1) begin
      errors++;
      $display("FAIL L0 fixed words: got n=%0d w0=%h last15=%0b want 16,80000000,1", obs_data.size(), obs_data[0], obs_msg[15]);
    end
  endtask

  task automatic test_l13_l14;
    for (int i = 0; i < 14; i++) mem[16'h0800 + 16'(i)] = $urandom;
    test_padding_stream("L13", 16'h0800, 8'd13, 100);
    checks++;
    if (obs_data.size() != 16 || obs_data[13] !== 32'h8000_0000 || obs_data[15] !== 32'd416) begin
      errors++; $display("FAIL L13 fixed words: got n=%0d w15=%0d want 16,416", obs_data.size(), obs_data[15]);
    end
    test_padding_stream("L14", 16'h0800, 8'd14, 100);
    checks++;
    if (obs_data.size() != 32 || obs_data[14] !== 32'h8000_0000 || obs_data[31] !== 32'd448) begin
      errors++; $display("FAIL L14 fixed words: got n=%0d w31=%0d want 32,448", obs_data.size(), obs_data[31]);
    end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 20; i++) mem[16'h1000 + 16'(i)] = 32'(i + 1);
    test_padding_stream("L20 bp50", 16'h1000, 8'd20, 50);
    test_padding_stream("L20 bp25", 16'h1000, 8'd20, 25);
  endtask

  task automatic test_random_lengths;
    logic [15:0] a;
    logic [7:0]  l;
    for (int k = 0; k < 7; k++) begin
      a = (k == 0) ? 16'hFFF8 : 16'($urandom);
      l = (k == 6) ? 8'd255 : 8'($urandom_range(0, 40));
      if (k == 6) a = 16'hFFC0;
      for (int i = 0; i < int'(l); i++) mem[a + 16'(i)] = $urandom;
      test_padding_stream($sformatf("rand%0d L%0d", k, l), a, l, (k == 6) ? 100 : int'($urandom_range(30, 100)));
    end
  endtask

  task automatic test_reset_mid;
    int n, cyc;
    for (int i = 0; i < 20; i++) mem[16'h0200 + 16'(i)] = 32'(i + 1);
    @(negedge clk);
    start = 1'b1; message_addr = 16'h0200; msg_words = 8'd20; w_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    n = 0; cyc = 0;
    while (cyc < 200) begin
      if (w_valid) begin
        if (n == 7) break;
        n++;
      end
      @(negedge clk); #1; cyc++;
    end
    checks++;
    if (w_valid !== 1'b1 || w_data !== 32'd8) begin
      errors++; $display("FAIL midreset word7: got valid=%0b data=%h want 1,00000008", w_valid, w_data);
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (w_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || w_data !== 32'h0 || mem_addr !== 16'h0) begin
        errors++;
        $display("FAIL midreset idle%0d: got valid=%0b busy=%0b done=%0b data=%h addr=%h want 0", c,
                 w_valid, busy, done, w_data, mem_addr);
      end
      @(negedge clk);
    end
    mem[16'h0300] = 32'hCAFE_0001;
    test_padding_stream("restart L1", 16'h0300, 8'd1, 100);
    checks++;
    if (obs_data.size() != 16 || obs_data[15] !== 32'd32) begin
      errors++; $display("FAIL restart L1 len word: got n=%0d w15=%0d want 16,32", obs_data.size(), obs_data[15]);
    end
  endtask

  task automatic test_bswap;
    logic [31:0] want0;
`ifdef SHA256_PAD_BSWAP_EN
    want0 = 32'h0403_0201;
`else
    want0 = 32'h0102_0304;
`endif
    mem[16'h0400] = 32'h0102_0304;
    test_padding_stream("bswap", 16'h0400, 8'd1, 100);
    checks++;
    if (obs_data[0] !== want0 || obs_data[1] !== 32'h8000_0000) begin
      errors++; $display("FAIL bswap words: got w0=%h w1=%h want %h,80000000", obs_data[0], obs_data[1], want0);
    end
  endtask

  initial begin
    test_reset();
    test_l20();
    test_l0();
    test_l13_l14();
    test_backpressure();
    test_random_lengths();
    test_reset_mid();
    test_bswap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_padder.md
SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 SHALL have parameter LEN_W, default 8, width of message length in 32-bit words.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to pad a message; ignored while busy=1.
REQ-006 SHALL have port message_addr, input, ADDR_W, word address of message word 0; sampled with start.
REQ-007 SHALL have port msg_words, input, LEN_W, message length L in words (0..2^LEN_W-1); sampled with start.
REQ-008 SHALL have port mem_addr, output, ADDR_W, read address to message memory.
REQ-009 SHALL have port mem_read_data, input, 32, memory data, valid exactly one cycle after mem_addr.
REQ-010 SHALL have port w_valid, output, 1, w_data holds a schedule word.
REQ-011 SHALL have port w_ready, input, 1, downstream hash core accepts the word.
REQ-012 SHALL have port w_data, output, 32, padded message word.
REQ-013 SHALL have port w_blk_last, output, 1, current word is word 15 of a block.
REQ-014 SHALL have port w_msg_last, output, 1, current word is the final word of the final block.
REQ-015 SHALL have port busy, output, 1, high from cycle after accepted start until final word transferred.
REQ-016 SHALL have port done, output, 1, one-cycle pulse the cycle after the final transfer.

Function
REQ-017 SHALL transfer a word only on a cycle with w_valid=1 and w_ready=1; w_data, w_blk_last and w_msg_last SHALL hold stable while w_valid=1 and w_ready=0.
REQ-018 SHALL emit word stream: L message words (mem[message_addr+i]), 32'h8000_0000, Z zero words, 32'h0 (length high), L*32 (length low, zero-extended), so that total word count is 16*N.
REQ-019 SHALL use block count N = floor((L+18)/16); Z = 16*N - L - 3.
REQ-020 SHALL sequence states IDLE -> MSG (skipped if L=0) -> PAD -> ZERO (skipped if Z=0) -> LENHI -> LENLO -> IDLE, with advance only on transfer of the last word of each state.
REQ-021 SHALL issue memory reads sequentially, prefetching so that with w_ready held high the stream sustains one word per cycle; first w_valid SHALL assert no later than 2 cycles after start.
REQ-022 SHALL never read beyond message_addr+L-1 and never drop or duplicate a word under arbitrary w_ready backpressure.
REQ-023 SHALL count words within a block with a 4-bit counter wrapping 15->0; w_blk_last=1 when counter=15.
REQ-024 SHALL compute address as message_addr+i modulo 2^ADDR_W (wrap-around permitted).
REQ-025 SHALL ignore start asserted in the same cycle as done or while busy=1.

Reset
REQ-026 SHALL, on reset_n=0 at a rising edge, force state IDLE and drive w_valid=0, w_blk_last=0, w_msg_last=0, busy=0, done=0, w_data=0, mem_addr=0.
REQ-027 SHALL, on reset mid-message, abandon the message, discard prefetched data, and issue no further reads until a new start.

Configuration
REQ-028 SHALL, with macro SHA256_PAD_BSWAP_EN defined, byte-reverse each message word ({b0,b1,b2,b3}) before output; padding and length words are never swapped.
REQ-029 SHALL, without SHA256_PAD_BSWAP_EN, pass message words unmodified.

Structure
REQ-030 SHALL place the state enum, PAD_WORD (32'h8000_0000) and BLOCK_WORDS (16) in shared package sha256_pkg.
REQ-031 SHALL implement the backpressure buffer as sub-module sha256_skid (2-entry, 33-bit incl. flags).

Verification
REQ-032 SHALL cover L=20, mem[a+i]=i+1, w_ready=1: 32 words, word 20=32'h8000_0000, words 21..29=0, word 30=0, word 31=640; w_blk_last at 15,31; done once.
REQ-033 SHALL cover L=0: 16 words, word0=32'h8000_0000, words1..15=0, w_msg_last on word 15.
REQ-034 SHALL cover L=13 (N=1, Z=0, word15=416) and L=14 (N=2, Z=15, word31=448).
REQ-035 SHALL cover L=20 with random w_ready (50%): identical word sequence to REQ-032, mem_addr never exceeds a+19.
REQ-036 SHALL cover reset_n low at word 7 then start with L=1: clean restart, 16 words, word15=32.
REQ-037 SHALL cover SHA256_PAD_BSWAP_EN with mem word 32'h0102_0304: output 32'h0403_0201, pad word unchanged.
